// File: rtl/apb_slave_regs_if.sv
// APB slave bus bundle for apb_slave_regs: setup/access handshake, address/data and response.
interface apb_slave_regs_if;
    logic        sel;
    logic        enable;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        slvERR;

    modport master (
        output sel, enable, write, addr, wdata,
        input  ready, rdata, slvERR
    );

    modport slave (
        input  sel, enable, write, addr, wdata,
        output ready, rdata, slvERR
    );
endinterface

// File: rtl/apb_slave_regs.sv
// APB register slave: NUM_REGS-1 read/write words plus a read-only transfer counter in the top slot.
// Optional wait states are enabled by defining APB_SLV_WAIT_EN (WAIT_CYCLES per transfer).
module apb_slave_regs #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    apb_slave_regs_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e      state_q;
    logic        ready_q;
    logic        write_q;
    logic        err_q;
    logic [3:0]  idx_q;
    logic [31:0] wdata_q;
    logic [31:0] xfer_cnt_q;
    logic [31:0] regs_q [NUM_REGS-1];
`ifdef APB_SLV_WAIT_EN
    logic [3:0]  wait_cnt_q;
`else
    logic        unused_wait_cycles;
    assign unused_wait_cycles = ^4'(WAIT_CYCLES);
`endif

    logic        setup_err;
    logic        complete;
    logic [31:0] rd_val;

    // Legality is decided from the setup-phase inputs and held for the whole transfer.
    assign setup_err = (bus.addr[1:0] != 2'b00) ||
                       (bus.addr >= 32'(NUM_REGS * 4)) ||
                       (bus.write && (bus.addr[5:2] == 4'(NUM_REGS - 1)));
    assign complete  = bus.sel && bus.enable && ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= 4'd0;
            wdata_q    <= 32'd0;
            xfer_cnt_q <= 32'd0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= 32'd0;
            end
`ifdef APB_SLV_WAIT_EN
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // enable without a preceding setup phase is ignored here
                    if (bus.sel && !bus.enable) begin
                        state_q <= StAccess;
                        idx_q   <= bus.addr[5:2];
                        write_q <= bus.write;
                        wdata_q <= bus.wdata;
                        err_q   <= setup_err;
`ifdef APB_SLV_WAIT_EN
                        wait_cnt_q <= 4'(WAIT_CYCLES);
                        ready_q    <= (WAIT_CYCLES == 0);
`else
                        ready_q    <= 1'b1;
`endif
                    end
                end
                StAccess, StWait: begin
                    if (!bus.sel) begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                    end else if (complete) begin
                        state_q    <= StIdle;
                        ready_q    <= 1'b0;
                        xfer_cnt_q <= xfer_cnt_q + 32'd1;
                        if (write_q && !err_q) begin
                            for (int i = 0; i < NUM_REGS - 1; i++) begin
                                if (idx_q == 4'(i)) begin
                                    regs_q[i] <= wdata_q;
                                end
                            end
                        end
`ifdef APB_SLV_WAIT_EN
                    end else if (wait_cnt_q != 4'd0) begin
                        state_q    <= StWait;
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                        ready_q    <= (wait_cnt_q == 4'd1);
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_val = 32'd0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (idx_q == 4'(i)) begin
                rd_val = regs_q[i];
            end
        end
        if (idx_q == 4'(NUM_REGS - 1)) begin
            rd_val = xfer_cnt_q;
        end
    end

    // Outputs are masked while reset is high so nothing leaks before the reset edge.
    assign bus.ready  = ready_q && !reset;
    assign bus.rdata  = (bus.ready && !write_q && !err_q) ? rd_val : 32'd0;
    assign bus.slvERR = bus.ready && err_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: vector table, hand-written corner cases, random vs. model.
module tb_apb_slave_regs;
    localparam int NREGS = 8;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic clk;
    logic reset;
    apb_slave_regs_if bus ();

    apb_slave_regs #(.NUM_REGS(NREGS), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: plain array of words plus a transfer count.
    logic [31:0] m_regs [NREGS-1];
    logic [31:0] m_cnt;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit m_illegal(input bit wr, input logic [31:0] a);
        return (a % 4 != 0) || (a >= NREGS * 4) || (wr && (a / 4 == NREGS - 1));
    endfunction

    // Returns expected response and applies the transfer's effect to the model.
    task automatic m_apply(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output bit er);
        int w;
        er = m_illegal(wr, a);
        w  = int'(a / 4);
        rd = 32'd0;
        if (!wr && !er) rd = (w == NREGS - 1) ? m_cnt : m_regs[w];
        if (wr && !er) m_regs[w] = d;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS - 1; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    // Entered and left on a negedge; leaves sel low so a following call is back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, output logic [31:0] rd, output logic er);
        int waits;
        bus.sel = 1'b1; bus.enable = 1'b0; bus.write = wr; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.enable = 1'b1;
        if (scramble) begin
            bus.addr = a ^ 32'h0000_0004; bus.wdata = ~d; bus.write = ~wr;
        end
        waits = 0;
        while (!bus.ready && waits < 40) begin
            check("rdata_while_waiting", bus.rdata, 32'd0);
            @(negedge clk);
            waits++;
        end
        check("ready_latency", 32'(waits), 32'(EXP_WAIT));
        rd = bus.rdata;
        er = bus.slvERR;
        @(negedge clk);
        check("ready_after_complete", 32'(bus.ready), 32'd0);
        bus.sel = 1'b0; bus.enable = 1'b0;
    endtask

    task automatic xfer_model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input string name);
        logic [31:0] rd, exp_rd;
        logic        er;
        bit          exp_er;
        m_apply(wr, a, d, exp_rd, exp_er);
        xfer(wr, a, d, 1'b0, rd, er);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er;
        bit          exp_er;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20, 32'h1111_1111, 32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h02, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b1, 32'h1C, 32'h2222_2222, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h1C, 32'h0,         32'h5,         1'b0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0,         32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h18, 32'hA5A5_0001, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h18, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[9]  = '{1'b0, 32'h04, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{1'b0, 32'h1C, 32'h0,         32'd10,        1'b0};

        reset = 1'b1;
        bus.sel = 1'b1; bus.enable = 1'b1; bus.write = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_slverr", 32'(bus.slvERR), 32'd0);
        bus.sel = 1'b0; bus.enable = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd0);

        // Table: back-to-back transfers with fixed expectations.
        foreach (vecs[i]) begin
            m_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // enable without setup must not start a transfer.
        bus.sel = 1'b1; bus.enable = 1'b1; bus.addr = 32'h0; bus.write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_enable_ready", 32'(bus.ready), 32'd0);
        end
        bus.sel = 1'b0; bus.enable = 1'b0;
        @(negedge clk);

        // Abort: sel dropped before completion.
        bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 32'h8; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (EXP_WAIT > 0 ? 1 : 0) @(negedge clk);
        bus.sel = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(bus.ready), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        xfer_model(1'b0, 32'h08, 32'h0, "abort_reg");
        xfer_model(1'b0, 32'h1C, 32'h0, "abort_cnt");

        // Inputs changed during access must not alter the captured transfer.
        m_apply(1'b1, 32'h10, 32'h0BAD_F00D, exp_rd, exp_er);
        xfer(1'b1, 32'h10, 32'h0BAD_F00D, 1'b1, rd, er);
        check("scramble_err", 32'(er), 32'd0);
        xfer_model(1'b0, 32'h10, 32'h0, "scramble_rd");
        xfer_model(1'b0, 32'h14, 32'h0, "scramble_nb");

        // Random traffic against the model, with random idle gaps.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                8:       a = 32'h20 + 4 * $urandom_range(0, 8);
                9:       a = 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
                default: a = 4 * $urandom_range(0, 7);
            endcase
            xfer_model(1'($urandom_range(0, 1)), a, $urandom, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Counter wrap.
        force dut.xfer_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        xfer_model(1'b0, 32'h1C, 32'h0, "wrap_read");
        xfer_model(1'b0, 32'h1C, 32'h0, "wrap_after");

        // Reset on the completion edge of a write.
        bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 32'h0; bus.wdata = 32'h55;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int w = 0; w < 40 && !bus.ready; w++) @(negedge clk);
        check("rst_mid_ready_before", 32'(bus.ready), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 32'(bus.ready), 32'd0);
        check("rst_mid_slverr", 32'(bus.slvERR), 32'd0);
        check("rst_mid_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; bus.sel = 1'b0; bus.enable = 1'b0;
        m_reset();
        @(negedge clk);
        xfer_model(1'b0, 32'h00, 32'h0, "rst_mid_reg");
        xfer_model(1'b0, 32'h1C, 32'h0, "rst_mid_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
